// File: rtl/int_event_gen_pkg.sv
// Shared definitions for the DMA interrupt event producer: flag bit indices,
// special descriptor codes, queue entry layout and the descriptor code packer.
package int_event_gen_pkg;

  localparam int FLAG_OP_DONE         = 0;
  localparam int FLAG_WR_ERR          = 1;
  localparam int FLAG_RD_ERR          = 2;
  localparam int FLAG_INVALID_DSCRPTR = 3;

  localparam logic [5:0] DSCRPTR_CODE_EXT = 6'd32;
  localparam logic [5:0] DSCRPTR_CODE_STR = 6'd33;

  localparam int ENTRY_W   = 42;
  localparam int FLAGS_LSB = 0;
  localparam int CODE_LSB  = 4;
  localparam int ADDR_LSB  = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } evtState_e;

  // Stream descriptors win over external ones when an engine reports both.
  function automatic logic [5:0] packCode(input logic strDscrptr,
                                          input logic extDscrptr,
                                          input logic [4:0] dscrptrNum);
    if (strDscrptr) begin
      return DSCRPTR_CODE_STR;
    end else if (extDscrptr) begin
      return DSCRPTR_CODE_EXT;
    end else begin
      return {1'b0, dscrptrNum};
    end
  endfunction

endpackage

// File: rtl/int_event_rr_arb.sv
// Round-robin arbiter: grants the first requester found starting at rr_ptr_i,
// wrapping modulo N. Grant is purely combinational and gated by enable_i.
module int_event_rr_arb #(
  parameter int N = 4,
  localparam int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic             enable_i,
  input  logic [PTR_W-1:0] rr_ptr_i,
  output logic [N-1:0]     grant_o,
  output logic [PTR_W-1:0] grant_idx_o
);

  logic             found;
  logic [PTR_W:0]   candSum;
  logic [PTR_W-1:0] candIdx;

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    candSum     = '0;
    candIdx     = '0;
    for (int i = 0; i < N; i++) begin
      candSum = {1'b0, rr_ptr_i} + (PTR_W + 1)'(i);
      if (candSum >= (PTR_W + 1)'(N)) begin
        candSum = candSum - (PTR_W + 1)'(N);
      end
      candIdx = candSum[PTR_W-1:0];
      if (enable_i && !found && req_i[candIdx]) begin
        found          = 1'b1;
        grant_o[candIdx] = 1'b1;
        grant_idx_o    = candIdx;
      end
    end
  end

endmodule

// File: rtl/int_event_gen.sv
// Interrupt event producer: arbitrates per-channel DMA events round-robin and
// pushes packed 42-bit entries into the interrupt queue through a one-entry buffer.
module int_event_gen
  import int_event_gen_pkg::*;
#(
  parameter int NUM_CHANNELS = 4
) (
  input  logic                      clock,
  input  logic                      resetn,
  input  logic [NUM_CHANNELS-1:0]   ch_evt_valid,
  output logic [NUM_CHANNELS-1:0]   ch_evt_ready,
  input  logic [4*NUM_CHANNELS-1:0] ch_flags,
  input  logic [5*NUM_CHANNELS-1:0] ch_dscrptr_num,
  input  logic [NUM_CHANNELS-1:0]   ch_ext_dscrptr,
  input  logic [NUM_CHANNELS-1:0]   ch_str_dscrptr,
  input  logic [32*NUM_CHANNELS-1:0] ch_ext_addr,
  input  logic                      queue_full,
  output logic                      q_push,
  output logic [ENTRY_W-1:0]        q_data,
  output logic                      pend
);

  localparam int PTR_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

  evtState_e               state_q, state_d;
  logic [ENTRY_W-1:0]      entry_q, entry_d;
  logic [PTR_W-1:0]        rrPtr_q, rrPtr_d;

  logic [NUM_CHANNELS-1:0] grant;
  logic [PTR_W-1:0]        grantIdx;
  logic                    grantValid;
  logic                    canAccept;
  logic                    arbEnable;
  logic [3:0]              selFlags;
  logic [4:0]              selNum;
  logic                    selExt;
  logic                    selStr;
  logic [31:0]             selAddr;
  logic                    anyFlag;

  assign pend      = (state_q == ST_PEND);
  assign q_push    = pend & ~queue_full;
  assign q_data    = entry_q;
  // Gating with resetn keeps ready low while reset is held even if engines request.
  assign canAccept = ~pend | q_push;
  assign arbEnable = canAccept & resetn;

  int_event_rr_arb #(
    .N (NUM_CHANNELS)
  ) u_arb (
    .req_i       (ch_evt_valid),
    .enable_i    (arbEnable),
    .rr_ptr_i    (rrPtr_q),
    .grant_o     (grant),
    .grant_idx_o (grantIdx)
  );

  assign grantValid   = |grant;
  assign ch_evt_ready = grant;

  always_comb begin
    selFlags = '0;
    selNum   = '0;
    selExt   = 1'b0;
    selStr   = 1'b0;
    selAddr  = '0;
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      if (grantIdx == PTR_W'(k)) begin
        selFlags = ch_flags[k*4 +: 4];
        selNum   = ch_dscrptr_num[k*5 +: 5];
        selExt   = ch_ext_dscrptr[k];
        selStr   = ch_str_dscrptr[k];
        selAddr  = ch_ext_addr[k*32 +: 32];
      end
    end
  end

  assign anyFlag = selFlags[FLAG_OP_DONE] | selFlags[FLAG_WR_ERR] |
                   selFlags[FLAG_RD_ERR]  | selFlags[FLAG_INVALID_DSCRPTR];

  // Flag-less events are acknowledged but dropped; the buffer only drains.
  always_comb begin
    state_d = state_q;
    entry_d = entry_q;
    rrPtr_d = rrPtr_q;
    if (grantValid) begin
      rrPtr_d = (grantIdx == PTR_W'(NUM_CHANNELS - 1)) ? '0 : grantIdx + 1'b1;
    end
    if (grantValid && anyFlag) begin
      entry_d[FLAGS_LSB +: 4] = selFlags;
      entry_d[CODE_LSB +: 6]  = packCode(selStr, selExt, selNum);
      entry_d[ADDR_LSB +: 32] = selAddr;
      state_d                 = ST_PEND;
    end else if (q_push) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      entry_q <= '0;
      rrPtr_q <= '0;
    end else begin
      state_q <= state_d;
      entry_q <= entry_d;
      rrPtr_q <= rrPtr_d;
    end
  end

endmodule

// File: tb/tb_int_event_gen.sv
// Directed self-checking bench for int_event_gen with four channels.
module tb_int_event_gen;

  logic         clock = 1'b0;
  logic         resetn;
  logic [3:0]   chEvtValid;
  logic [3:0]   chEvtReady;
  logic [15:0]  chFlags;
  logic [19:0]  chDscrptrNum;
  logic [3:0]   chExt;
  logic [3:0]   chStr;
  logic [127:0] chExtAddr;
  logic         queueFull;
  logic         qPush;
  logic [41:0]  qData;
  logic         pend;

  int compared   = 0;
  int mismatched = 0;

  always #5 clock = ~clock;

  int_event_gen #(
    .NUM_CHANNELS (4)
  ) dut (
    .clock          (clock),
    .resetn         (resetn),
    .ch_evt_valid   (chEvtValid),
    .ch_evt_ready   (chEvtReady),
    .ch_flags       (chFlags),
    .ch_dscrptr_num (chDscrptrNum),
    .ch_ext_dscrptr (chExt),
    .ch_str_dscrptr (chStr),
    .ch_ext_addr    (chExtAddr),
    .queue_full     (queueFull),
    .q_push         (qPush),
    .q_data         (qData),
    .pend           (pend)
  );

  task automatic nextCycle();
    @(posedge clock);
    #1;
  endtask

  task automatic setChannel(input int ch, input logic [3:0] f, input logic [4:0] num,
                            input logic ext, input logic str, input logic [31:0] addr);
    chFlags[ch*4 +: 4]       = f;
    chDscrptrNum[ch*5 +: 5]  = num;
    chExt[ch]                = ext;
    chStr[ch]                = str;
    chExtAddr[ch*32 +: 32]   = addr;
  endtask

  function automatic logic [41:0] fairEntry(input int c);
    logic [31:0] a;
    logic [5:0]  code;
    logic [3:0]  f;
    a    = 32'hC000_0000 + 32'(c);
    code = 6'(10 + c);
    f    = 4'(c + 1);
    return {a, code, f};
  endfunction

  task automatic test_reset();
    repeat (2) @(posedge clock);
    #1;
    compared++; if (pend !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_pend: got %b want 0", pend); end
    compared++; if (qPush !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_push: got %b want 0", qPush); end
    compared++; if (qData !== 42'h0) begin mismatched++; $display("[TB] FAIL reset_data: got %h want 0", qData); end
    compared++; if (chEvtReady !== 4'b0000) begin mismatched++; $display("[TB] FAIL reset_ready: got %b want 0000", chEvtReady); end
    resetn = 1'b1;
  endtask

  task automatic test_single();
    nextCycle();
    setChannel(0, 4'b0001, 5'd5, 1'b0, 1'b0, 32'h0);
    chEvtValid = 4'b0001;
    #1;
    compared++; if (chEvtReady !== 4'b0001) begin mismatched++; $display("[TB] FAIL single_ready: got %b want 0001", chEvtReady); end
    compared++; if (qPush !== 1'b0) begin mismatched++; $display("[TB] FAIL single_nopush: got %b want 0", qPush); end
    nextCycle();
    chEvtValid = 4'b0000;
    #1;
    compared++; if (qPush !== 1'b1) begin mismatched++; $display("[TB] FAIL single_push: got %b want 1", qPush); end
    compared++; if (qData !== {32'h0, 6'd5, 4'b0001}) begin mismatched++; $display("[TB] FAIL single_data: got %h want %h", qData, {32'h0, 6'd5, 4'b0001}); end
    compared++; if (pend !== 1'b1) begin mismatched++; $display("[TB] FAIL single_pend: got %b want 1", pend); end
    compared++; if (chEvtReady !== 4'b0000) begin mismatched++; $display("[TB] FAIL single_noready: got %b want 0000", chEvtReady); end
    nextCycle();
    #1;
    compared++; if (pend !== 1'b0) begin mismatched++; $display("[TB] FAIL single_drain: got %b want 0", pend); end
    compared++; if (qPush !== 1'b0) begin mismatched++; $display("[TB] FAIL single_idlepush: got %b want 0", qPush); end
  endtask

  task automatic test_code();
    nextCycle();
    setChannel(1, 4'b0010, 5'd4, 1'b1, 1'b1, 32'hDEAD_BEEC);
    chEvtValid = 4'b0010;
    #1;
    compared++; if (chEvtReady !== 4'b0010) begin mismatched++; $display("[TB] FAIL code_ready: got %b want 0010", chEvtReady); end
    nextCycle();
    chStr[1] = 1'b0;
    #1;
    compared++; if (qPush !== 1'b1) begin mismatched++; $display("[TB] FAIL code_push: got %b want 1", qPush); end
    compared++; if (qData !== {32'hDEAD_BEEC, 6'd33, 4'b0010}) begin mismatched++; $display("[TB] FAIL code_str: got %h want %h", qData, {32'hDEAD_BEEC, 6'd33, 4'b0010}); end
    compared++; if (chEvtReady !== 4'b0010) begin mismatched++; $display("[TB] FAIL code_regrant: got %b want 0010", chEvtReady); end
    nextCycle();
    chEvtValid = 4'b0000;
    #1;
    compared++; if (qData !== {32'hDEAD_BEEC, 6'd32, 4'b0010}) begin mismatched++; $display("[TB] FAIL code_ext: got %h want %h", qData, {32'hDEAD_BEEC, 6'd32, 4'b0010}); end
    compared++; if (qPush !== 1'b1) begin mismatched++; $display("[TB] FAIL code_push2: got %b want 1", qPush); end
    nextCycle();
    #1;
    compared++; if (pend !== 1'b0) begin mismatched++; $display("[TB] FAIL code_drain: got %b want 0", pend); end
  endtask

  task automatic test_drop();
    nextCycle();
    setChannel(2, 4'b0000, 5'd1, 1'b0, 1'b0, 32'h0000_0011);
    chEvtValid = 4'b0100;
    #1;
    compared++; if (chEvtReady !== 4'b0100) begin mismatched++; $display("[TB] FAIL drop_ready: got %b want 0100", chEvtReady); end
    compared++; if (qPush !== 1'b0) begin mismatched++; $display("[TB] FAIL drop_nopush: got %b want 0", qPush); end
    nextCycle();
    setChannel(3, 4'b1000, 5'd7, 1'b0, 1'b0, 32'h1234_5678);
    chEvtValid = 4'b1000;
    #1;
    compared++; if (pend !== 1'b0) begin mismatched++; $display("[TB] FAIL drop_pend: got %b want 0", pend); end
    compared++; if (qPush !== 1'b0) begin mismatched++; $display("[TB] FAIL drop_push: got %b want 0", qPush); end
    compared++; if (chEvtReady !== 4'b1000) begin mismatched++; $display("[TB] FAIL drop_next_ready: got %b want 1000", chEvtReady); end
    nextCycle();
    chEvtValid = 4'b0000;
    #1;
    compared++; if (qPush !== 1'b1) begin mismatched++; $display("[TB] FAIL drop_next_push: got %b want 1", qPush); end
    compared++; if (qData !== {32'h1234_5678, 6'd7, 4'b1000}) begin mismatched++; $display("[TB] FAIL drop_next_data: got %h want %h", qData, {32'h1234_5678, 6'd7, 4'b1000}); end
    nextCycle();
    #1;
    compared++; if (pend !== 1'b0) begin mismatched++; $display("[TB] FAIL drop_drain: got %b want 0", pend); end
  endtask

  task automatic test_fairness();
    logic [3:0] expReady;
    nextCycle();
    for (int c = 0; c < 4; c++) begin
      setChannel(c, 4'(c + 1), 5'(10 + c), 1'b0, 1'b0, 32'hC000_0000 + 32'(c));
    end
    chEvtValid = 4'b1111;
    for (int n = 0; n < 6; n++) begin
      if (n > 0) nextCycle();
      #1;
      expReady = 4'(1 << (n % 4));
      compared++; if (chEvtReady !== expReady) begin mismatched++; $display("[TB] FAIL fair_ready%0d: got %b want %b", n, chEvtReady, expReady); end
      compared++; if (qPush !== (n > 0)) begin mismatched++; $display("[TB] FAIL fair_push%0d: got %b want %b", n, qPush, (n > 0)); end
      if (n > 0) begin
        compared++; if (qData !== fairEntry((n - 1) % 4)) begin mismatched++; $display("[TB] FAIL fair_data%0d: got %h want %h", n, qData, fairEntry((n - 1) % 4)); end
      end
    end
    nextCycle();
    chEvtValid = 4'b0000;
    #1;
    compared++; if (qPush !== 1'b1) begin mismatched++; $display("[TB] FAIL fair_lastpush: got %b want 1", qPush); end
    compared++; if (qData !== fairEntry(1)) begin mismatched++; $display("[TB] FAIL fair_lastdata: got %h want %h", qData, fairEntry(1)); end
    nextCycle();
    #1;
    compared++; if (pend !== 1'b0) begin mismatched++; $display("[TB] FAIL fair_drain: got %b want 0", pend); end
  endtask

  task automatic test_backpressure();
    logic [41:0] entryA;
    logic [41:0] entryB;
    entryA = {32'hAAAA_0000, 6'd3, 4'b0100};
    entryB = {32'hBBBB_0000, 6'd9, 4'b0001};
    nextCycle();
    setChannel(2, 4'b0100, 5'd3, 1'b0, 1'b0, 32'hAAAA_0000);
    chEvtValid = 4'b0100;
    #1;
    compared++; if (chEvtReady !== 4'b0100) begin mismatched++; $display("[TB] FAIL bp_ready: got %b want 0100", chEvtReady); end
    nextCycle();
    setChannel(3, 4'b0001, 5'd9, 1'b0, 1'b0, 32'hBBBB_0000);
    chEvtValid = 4'b1000;
    queueFull  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) nextCycle();
      #1;
      compared++; if (qPush !== 1'b0) begin mismatched++; $display("[TB] FAIL bp_push%0d: got %b want 0", k, qPush); end
      compared++; if (chEvtReady !== 4'b0000) begin mismatched++; $display("[TB] FAIL bp_ready%0d: got %b want 0000", k, chEvtReady); end
      compared++; if (qData !== entryA) begin mismatched++; $display("[TB] FAIL bp_data%0d: got %h want %h", k, qData, entryA); end
      compared++; if (pend !== 1'b1) begin mismatched++; $display("[TB] FAIL bp_pend%0d: got %b want 1", k, pend); end
    end
    nextCycle();
    queueFull = 1'b0;
    #1;
    compared++; if (qPush !== 1'b1) begin mismatched++; $display("[TB] FAIL bp_release_push: got %b want 1", qPush); end
    compared++; if (chEvtReady !== 4'b1000) begin mismatched++; $display("[TB] FAIL bp_refill_ready: got %b want 1000", chEvtReady); end
    compared++; if (qData !== entryA) begin mismatched++; $display("[TB] FAIL bp_release_data: got %h want %h", qData, entryA); end
    nextCycle();
    chEvtValid = 4'b0000;
    #1;
    compared++; if (qPush !== 1'b1) begin mismatched++; $display("[TB] FAIL bp_refill_push: got %b want 1", qPush); end
    compared++; if (qData !== entryB) begin mismatched++; $display("[TB] FAIL bp_refill_data: got %h want %h", qData, entryB); end
    nextCycle();
    #1;
    compared++; if (pend !== 1'b0) begin mismatched++; $display("[TB] FAIL bp_drain: got %b want 0", pend); end
  endtask

  task automatic test_reset_midop();
    nextCycle();
    setChannel(1, 4'b0010, 5'd2, 1'b0, 1'b0, 32'h0000_5555);
    chEvtValid = 4'b0010;
    queueFull  = 1'b1;
    #1;
    compared++; if (chEvtReady !== 4'b0010) begin mismatched++; $display("[TB] FAIL rst_pre_ready: got %b want 0010", chEvtReady); end
    nextCycle();
    setChannel(0, 4'b0001, 5'd1, 1'b0, 1'b0, 32'h0A0A_0A0A);
    setChannel(3, 4'b1000, 5'd3, 1'b0, 1'b0, 32'h0B0B_0B0B);
    chEvtValid = 4'b1001;
    #1;
    compared++; if (pend !== 1'b1) begin mismatched++; $display("[TB] FAIL rst_pre_pend: got %b want 1", pend); end
    compared++; if (chEvtReady !== 4'b0000) begin mismatched++; $display("[TB] FAIL rst_pre_noready: got %b want 0000", chEvtReady); end
    #1;
    resetn = 1'b0;
    #1;
    compared++; if (pend !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_mid_pend: got %b want 0", pend); end
    compared++; if (qPush !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_mid_push: got %b want 0", qPush); end
    compared++; if (qData !== 42'h0) begin mismatched++; $display("[TB] FAIL rst_mid_data: got %h want 0", qData); end
    compared++; if (chEvtReady !== 4'b0000) begin mismatched++; $display("[TB] FAIL rst_mid_ready: got %b want 0000", chEvtReady); end
    nextCycle();
    resetn    = 1'b1;
    queueFull = 1'b0;
    #1;
    compared++; if (chEvtReady !== 4'b0001) begin mismatched++; $display("[TB] FAIL rst_post_ready: got %b want 0001", chEvtReady); end
    nextCycle();
    chEvtValid = 4'b0000;
    #1;
    compared++; if (qPush !== 1'b1) begin mismatched++; $display("[TB] FAIL rst_post_push: got %b want 1", qPush); end
    compared++; if (qData !== {32'h0A0A_0A0A, 6'd1, 4'b0001}) begin mismatched++; $display("[TB] FAIL rst_post_data: got %h want %h", qData, {32'h0A0A_0A0A, 6'd1, 4'b0001}); end
  endtask

  initial begin
    resetn       = 1'b0;
    chEvtValid   = '0;
    chFlags      = '0;
    chDscrptrNum = '0;
    chExt        = '0;
    chStr        = '0;
    chExtAddr    = '0;
    queueFull    = 1'b0;
    test_reset();
    test_single();
    test_code();
    test_drop();
    test_fairness();
    test_backpressure();
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/int_event_gen.md
Name: int_event_gen

Overview:
- Producer side of the DMA interrupt event queue. Collects completion and error events from NUM_CHANNELS descriptor-execution engines.
- Arbitrates round-robin between channels and packs each granted event into the 42-bit entry format the interrupt controller queue consumes.
- Pushes entries with a single-cycle push strobe, honouring the queue-full backpressure flag.
- Sits between the per-channel DMA engines and the interrupt controller.

Parameters:
NUM_CHANNELS, 4, number of requesting engines; legal range 1..4.

Ports:
clock  input  1  system clock; all logic on the rising edge
resetn  input  1  asynchronous active-low reset
ch_evt_valid  input  NUM_CHANNELS  per-channel event request; held until the matching ch_evt_ready
ch_evt_ready  output  NUM_CHANNELS  one-hot accept pulse for the granted channel
ch_flags  input  4*NUM_CHANNELS  per channel: [0] op_done, [1] wr_err, [2] rd_err, [3] invalid_dscrptr
ch_dscrptr_num  input  5*NUM_CHANNELS  internal descriptor number 0..31
ch_ext_dscrptr  input  NUM_CHANNELS  event came from an external descriptor
ch_str_dscrptr  input  NUM_CHANNELS  event came from a stream descriptor
ch_ext_addr  input  32*NUM_CHANNELS  external descriptor address; passed through unchanged
queue_full  input  1  interrupt event queue cannot accept a push this cycle
q_push  output  1  single-cycle write strobe to the queue
q_data  output  42  {ext_addr[31:0], dscrptr_code[5:0], flags[3:0]}
pend  output  1  output holding register occupied (debug/status)

Behaviour:
- Reset: pend=0, q_push=0, q_data=0, ch_evt_ready=0, rr_ptr=0. Reset is asynchronous and may assert mid-operation. A held entry is discarded without being pushed. Channels that still assert valid are re-arbitrated after reset release.
- Code packing:
  - dscrptr_code = 33 if str_dscrptr=1; else 32 if ext_dscrptr=1; else {1'b0, dscrptr_num}.
  - str takes precedence when both str and ext are set.
- State: a single-entry holding register plus a pend flag. Two states:
  - IDLE (pend=0)
  - PEND (pend=1)
- q_push = pend & ~queue_full. This output is combinational from queue_full. q_data is the holding register, driven directly.
- Arbitration:
  - Round-robin. Search starts at rr_ptr and wraps modulo NUM_CHANNELS.
  - On a grant to channel k, rr_ptr <= (k+1) mod NUM_CHANNELS.
  - rr_ptr is unchanged when there is no grant.
- Grant enable: can_accept = ~pend | q_push. A grant happens only when can_accept=1 and at least one ch_evt_valid=1.
- On a grant:
  - ch_evt_ready[k]=1 for that cycle only. This output is combinational.
  - If flags!=0, the packed entry is loaded into the holding register and pend <= 1.
  - If flags==0, the event is dropped: ready is still asserted, nothing is loaded, and pend <= pend & ~q_push.
- No grant and q_push=1 -> pend <= 0, and q_data retains its value.
- Simultaneous push and grant: the holding register is refilled in the same cycle. Back-to-back sustained throughput is 1 entry per clock while queue_full=0.
- Latency: event accepted in cycle N -> q_push in cycle N+1 at the earliest.
- queue_full held high: the entry is held stable in PEND, no further grants are made, and q_data does not change.
- A channel never sees ready while its valid is low.

Decomposition:
- Shared package holds:
  - FLAG_* bit indices
  - DSCRPTR_CODE_EXT=6'd32 and DSCRPTR_CODE_STR=6'd33
  - ENTRY_W=42
  - entry field offsets (FLAGS_LSB=0, CODE_LSB=4, ADDR_LSB=10)
- Sub-module int_event_rr_arb: a NUM_CHANNELS-wide round-robin arbiter.
  - Inputs: req, enable, rr_ptr.
  - Outputs: one-hot grant, grant index.
  - Also reused by other requesters in the controller.

Test Plan:
- Single event: ch0 valid, flags=4'b0001, num=5, queue_full=0 -> ready[0] in cycle N; q_push in N+1 with q_data={32'h0, 6'd5, 4'b0001}; pend returns to 0 in N+2.
- Code precedence: ch1 with ext=1, str=1, addr=32'hDEAD_BEEC, flags=4'b0010 -> q_data[9:4]=33 and q_data[41:10]=32'hDEAD_BEEC. Repeat with str=0 -> code 32.
- Fairness: all 4 channels hold valid continuously with nonzero flags, queue_full=0 -> grants 0,1,2,3,0,1; one q_push per cycle after the first; no channel starved.
- Backpressure: queue_full=1 for 5 cycles while PEND -> q_push=0, q_data stable, no ready. queue_full drops -> push, with a refill grant in the same cycle.
- Drop: ch2 event with flags=0 -> ready[2] asserted, no q_push, pend unchanged. A following ch3 event with nonzero flags is pushed normally.
- Reset mid-operation: assert resetn=0 while PEND with queue_full=1 -> pend=0, q_push=0, q_data=0, rr_ptr=0 immediately. After release, the still-valid channel is granted first.
